seq_add32_ctrl: RTL and testbench

SEQ_ADD32_CTRL -- requirements
Module: seq_add32_ctrl

---
 rtl/seq_add32_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seq_add32_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_add32_ctrl.sv
// seq_add32_ctrl: performs one 32-bit addition as four byte steps through a
// shared external 8-bit ripple-carry adder. IDLE accepts start, RUN walks
// bytes 0..3 (LSB first) and DONE issues a single-cycle completion pulse.
// Optional feature: define SEQ_ADD32_SUB_EN to add the 'op' port; op=1
// selects a - b by inverting b bytes and forcing the initial carry to 1.
module seq_add32_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
`ifdef SEQ_ADD32_SUB_EN
    input  logic        op,
`endif
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_s,
    input  logic        add_cout,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  idx_r;
    logic        carry_r;
    logic [31:0] a_lat_r;
    logic [31:0] b_lat_r;
    logic        cin_lat_r;
    logic        sub_r;
    logic [31:0] sum_r;
    logic        cout_r;
    logic        busy_r;
    logic        done_r;
    logic        sub_sel_s;
    logic        first_carry_s;
    logic [7:0]  a_byte_s;
    logic [7:0]  b_byte_s;

    // Byte lane selector shared by both operand paths.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] res;
        case (lane)
            2'd0:    res = word[7:0];
            2'd1:    res = word[15:8];
            2'd2:    res = word[23:16];
            2'd3:    res = word[31:24];
            default: res = 8'h00;
        endcase
        return res;
    endfunction

`ifdef SEQ_ADD32_SUB_EN
    // Subtract mode selection and its initial carry, captured with the operands.
    always_comb begin
        sub_sel_s     = op;
        first_carry_s = op ? 1'b1 : cin;
    end
`else
    // Addition only: carry-in comes straight from cin.
    always_comb begin
        sub_sel_s     = 1'b0;
        first_carry_s = cin;
    end
`endif

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == 2'd3) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Adder operand drive: current byte lane in RUN, quiet zeros otherwise.
    always_comb begin
        a_byte_s = byte_sel(a_lat_r, idx_r);
        b_byte_s = byte_sel(b_lat_r, idx_r);
        add_a    = 8'h00;
        add_b    = 8'h00;
        add_cin  = 1'b0;
        if (state_r == RUN) begin
            add_a   = a_byte_s;
            add_b   = sub_r ? ~b_byte_s : b_byte_s;
            add_cin = (idx_r == 2'd0) ? cin_lat_r : carry_r;
        end else begin
            add_a   = 8'h00;
            add_b   = 8'h00;
            add_cin = 1'b0;
        end
    end

    // State, operand latches, byte-wise result accumulation and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= 2'd0;
            carry_r   <= 1'b0;
            a_lat_r   <= 32'h0000_0000;
            b_lat_r   <= 32'h0000_0000;
            cin_lat_r <= 1'b0;
            sub_r     <= 1'b0;
            sum_r     <= 32'h0000_0000;
            cout_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_lat_r   <= a;
                        b_lat_r   <= b;
                        cin_lat_r <= first_carry_s;
                        sub_r     <= sub_sel_s;
                        sum_r     <= 32'h0000_0000;
                        cout_r    <= 1'b0;
                        idx_r     <= 2'd0;
                        carry_r   <= 1'b0;
                    end else begin
                        idx_r <= 2'd0;
                    end
                end
                RUN: begin
                    case (idx_r)
                        2'd0:    sum_r[7:0]   <= add_s;
                        2'd1:    sum_r[15:8]  <= add_s;
                        2'd2:    sum_r[23:16] <= add_s;
                        2'd3:    sum_r[31:24] <= add_s;
                        default: sum_r        <= sum_r;
                    endcase
                    carry_r <= add_cout;
                    // idx 3 -> 0 happens only here, on the way into DONE.
                    idx_r   <= idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        cout_r <= add_cout;
                    end else begin
                        cout_r <= cout_r;
                    end
                end
                DONE: begin
                    idx_r <= 2'd0;
                end
                default: begin
                    idx_r <= 2'd0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_seq_add32_ctrl.sv
// Testbench for seq_add32_ctrl: models the external 8-bit adder, runs directed
// and random operations and compares against arithmetic expectations.
module tb_seq_add32_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_s;
    logic        add_cout;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;

    int n_checks;
    int n_pass;

    seq_add32_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SEQ_ADD32_SUB_EN
        .op       (op),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout)
    );

    // External shared 8-bit ripple-carry adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation with per-byte adder-drive checks and result checks.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic ocin,
                          input logic oop, input bit repulse);
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic [63:0] bb;
        logic [63:0] c0;
        logic [63:0] mask;
        logic [63:0] cin_i;
        logic [64:0] full;
        if (oop) begin
            exp_sum  = oa - ob;
            exp_cout = (oa >= ob);
            bb       = {32'h0, ~ob};
            c0       = 64'd1;
        end else begin
            full     = {33'h0, oa} + {33'h0, ob} + {64'h0, ocin};
            exp_sum  = full[31:0];
            exp_cout = full[32];
            bb       = {32'h0, ob};
            c0       = {63'h0, ocin};
        end
        a = oa; b = ob; cin = ocin; op = oop; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            mask  = (64'd1 << (8 * i)) - 64'd1;
            cin_i = (({32'h0, oa} & mask) + (bb & mask) + c0) >> (8 * i);
            check_val("busy_run", {63'h0, busy}, 64'd1);
            check_val("done_run", {63'h0, done}, 64'd0);
            check_val("add_a", {56'h0, add_a}, ({32'h0, oa} >> (8 * i)) & 64'hFF);
            check_val("add_b", {56'h0, add_b}, (bb >> (8 * i)) & 64'hFF);
            check_val("add_cin", {63'h0, add_cin}, cin_i & 64'd1);
            if (repulse && i == 1) begin
                start = 1'b1; a = 32'h0; b = 32'h0;
            end
            if (i == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        check_val("done_pulse", {63'h0, done}, 64'd1);
        check_val("busy_done", {63'h0, busy}, 64'd0);
        check_val("sum", {32'h0, sum}, {32'h0, exp_sum});
        check_val("cout", {63'h0, cout}, {63'h0, exp_cout});
        check_val("idle_drive", {47'h0, add_a, add_b, add_cin}, 64'd0);
        @(posedge clk); #1;
        check_val("done_single", {63'h0, done}, 64'd0);
        check_val("busy_after", {63'h0, busy}, 64'd0);
        check_val("sum_held", {32'h0, sum}, {32'h0, exp_sum});
        check_val("cout_held", {63'h0, cout}, {63'h0, exp_cout});
    endtask

    initial begin
        int done_cnt;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0; cin = 1'b0; op = 1'b0;
        #2;
        check_val("rst_busy", {63'h0, busy}, 64'd0);
        check_val("rst_done", {63'h0, done}, 64'd0);
        check_val("rst_sum", {32'h0, sum}, 64'd0);
        check_val("rst_cout", {63'h0, cout}, 64'd0);
        check_val("rst_drive", {47'h0, add_a, add_b, add_cin}, 64'd0);
        #10 rst_n = 1'b1;

        // First start right after reset release is accepted on the next edge.
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef SEQ_ADD32_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 1'b0);
        run_op(32'd9, 32'd9, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
`endif

        // Reset during RUN aborts immediately and yields no done pulse.
        a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", {63'h0, busy}, 64'd0);
        check_val("abort_done", {63'h0, done}, 64'd0);
        check_val("abort_sum", {32'h0, sum}, 64'd0);
        check_val("abort_cout", {63'h0, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check_val("abort_no_done", 64'(done_cnt), 64'd0);
        check_val("abort_idle", {63'h0, busy}, 64'd0);

        // Operation after an aborted one still works.
        run_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
